// File: rtl/fetch_decode_reg_if.sv
// fetch_decode_reg_if: fetch-to-decode bundle.
// master drives fetch inputs, slave is the pipeline register.
interface fetch_decode_reg_if #(
    parameter int IW = 9,
    parameter int AW = 8
);
    logic          Start;
    logic [AW-1:0] PC;
    logic [IW-1:0] InstrIn;
    logic          Stall;
    logic          Branch;
    logic [IW-1:0] Instr;
    logic [AW-1:0] InstrPC;
    logic          Valid;
    logic          Halt;
    logic          Done;
    logic [15:0]   InstrCount;

    modport master (
        output Start, PC, InstrIn, Stall, Branch,
        input  Instr, InstrPC, Valid, Halt, Done, InstrCount
    );

    modport slave (
        input  Start, PC, InstrIn, Stall, Branch,
        output Instr, InstrPC, Valid, Halt, Done, InstrCount
    );
endinterface

// File: rtl/fetch_decode_reg.sv
// fetch_decode_reg: IF/ID register with branch squash and HALT drain.
// Optional retired-fetch counter enabled by FETCH_PERF_CNT_EN.
module fetch_decode_reg #(
    parameter int            IW           = 9,
    parameter int            AW           = 8,
    parameter logic [IW-1:0] HALT_ENC     = 9'h1FF,
    parameter logic [IW-1:0] NOP_ENC      = 9'h000,
    parameter int            DRAIN_CYCLES = 3
) (
    input logic               clk,
    input logic               Init,
    fetch_decode_reg_if.slave bus
);
    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DRAIN,
        S_HALTED
    } state_t;

    localparam logic [3:0] DRAIN_LAST = 4'(DRAIN_CYCLES);

    state_t        r_state;
    state_t        w_state_nxt;
    logic [IW-1:0] r_instr;
    logic [IW-1:0] w_instr_nxt;
    logic [AW-1:0] r_pc;
    logic [AW-1:0] w_pc_nxt;
    logic          r_valid;
    logic          w_valid_nxt;
    logic [3:0]    r_drain;
    logic [3:0]    w_drain_nxt;
    logic [3:0]    w_drain_inc;

    assign w_drain_inc = r_drain + 4'd1;

    // Next-state and next datapath values for the IF/ID register
    always_comb begin
        w_state_nxt = r_state;
        w_instr_nxt = r_instr;
        w_pc_nxt    = r_pc;
        w_valid_nxt = r_valid;
        w_drain_nxt = r_drain;
        unique case (r_state)
            S_IDLE: begin
                w_instr_nxt = NOP_ENC;
                w_valid_nxt = 1'b0;
                if (bus.Start) begin
                    w_state_nxt = S_RUN;
                end
            end
            S_RUN: begin
                if (bus.Branch) begin
                    // wrong-path fetch, including a wrong-path HALT
                    w_instr_nxt = NOP_ENC;
                    w_valid_nxt = 1'b0;
                    w_pc_nxt    = bus.PC;
                end else if (bus.Stall) begin
                    w_instr_nxt = r_instr;
                end else begin
                    w_instr_nxt = bus.InstrIn;
                    w_pc_nxt    = bus.PC;
                    w_valid_nxt = 1'b1;
                    if (bus.InstrIn == HALT_ENC) begin
                        w_state_nxt = S_DRAIN;
                        w_drain_nxt = 4'd0;
                    end
                end
            end
            S_DRAIN: begin
                w_instr_nxt = NOP_ENC;
                w_valid_nxt = 1'b0;
                w_drain_nxt = w_drain_inc;
                if (w_drain_inc == DRAIN_LAST) begin
                    w_state_nxt = S_HALTED;
                end
            end
            S_HALTED: begin
                w_instr_nxt = NOP_ENC;
                w_valid_nxt = 1'b0;
                if (bus.Start) begin
                    w_state_nxt = S_RUN;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // State and pipeline registers
    always_ff @(posedge clk or posedge Init) begin
        if (Init) begin
            r_state <= S_IDLE;
            r_instr <= NOP_ENC;
            r_pc    <= '0;
            r_valid <= 1'b0;
            r_drain <= 4'd0;
        end else begin
            r_state <= w_state_nxt;
            r_instr <= w_instr_nxt;
            r_pc    <= w_pc_nxt;
            r_valid <= w_valid_nxt;
            r_drain <= w_drain_nxt;
        end
    end

    assign bus.Instr   = r_instr;
    assign bus.InstrPC = r_pc;
    assign bus.Valid   = r_valid;
    assign bus.Halt    = (r_state == S_DRAIN) || (r_state == S_HALTED);
    assign bus.Done    = (r_state == S_HALTED);

`ifdef FETCH_PERF_CNT_EN
    logic [15:0] r_icount;
    logic        w_fetch;
    logic        w_start_acc;

    assign w_fetch     = (r_state == S_RUN) && !bus.Branch && !bus.Stall;
    assign w_start_acc = bus.Start &&
                         ((r_state == S_IDLE) || (r_state == S_HALTED));

    // Saturating count of edges that load a real instruction
    always_ff @(posedge clk or posedge Init) begin
        if (Init) begin
            r_icount <= 16'h0000;
        end else if (w_start_acc) begin
            r_icount <= 16'h0000;
        end else if (w_fetch && (r_icount != 16'hFFFF)) begin
            r_icount <= r_icount + 16'd1;
        end
    end

    assign bus.InstrCount = r_icount;
`else
    assign bus.InstrCount = 16'h0000;
`endif

endmodule

// File: tb/tb_fetch_decode_reg.sv
// tb_fetch_decode_reg: directed plus random run against
// a behavioural fetch/decode register model.
module tb_fetch_decode_reg;
    localparam int DC = 3;
    localparam logic [8:0] HALTW = 9'h1FF;

    logic clk;
    logic Init;
    int   n_err;
    int   n_chk;

    fetch_decode_reg_if #(.IW(9), .AW(8)) bus ();

    fetch_decode_reg dut (
        .clk  (clk),
        .Init (Init),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // model state
    logic [8:0]  m_instr;
    logic [7:0]  m_pc;
    logic        m_valid;
    int          m_cnt;
    bit          m_started;
    bit          m_halted;
    int          m_drain_left;

    // current stimulus copies
    logic        s_start, s_br, s_stall;
    logic [7:0]  s_pc;
    logic [8:0]  s_ins;

    task automatic model_reset();
        m_instr      = 9'h000;
        m_pc         = 8'h00;
        m_valid      = 1'b0;
        m_cnt        = 0;
        m_started    = 1'b0;
        m_halted     = 1'b0;
        m_drain_left = 0;
    endtask

    task automatic model_edge();
        if (m_drain_left > 0) begin
            m_instr = 9'h000;
            m_valid = 1'b0;
            m_drain_left--;
            if (m_drain_left == 0) m_halted = 1'b1;
        end else if (m_halted || !m_started) begin
            m_instr = 9'h000;
            m_valid = 1'b0;
            if (s_start) begin
                m_halted  = 1'b0;
                m_started = 1'b1;
                m_cnt     = 0;
            end
        end else if (s_br) begin
            m_instr = 9'h000;
            m_valid = 1'b0;
            m_pc    = s_pc;
        end else if (!s_stall) begin
            m_instr = s_ins;
            m_pc    = s_pc;
            m_valid = 1'b1;
            if (m_cnt < 65535) m_cnt++;
            if (s_ins == HALTW) m_drain_left = DC;
        end
    endtask

    task automatic cmp(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        assert (got === exp) else begin
            n_err++;
            $error("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic check_all(input string tag);
        int exp_cnt;
`ifdef FETCH_PERF_CNT_EN
        exp_cnt = m_cnt;
`else
        exp_cnt = 0;
`endif
        cmp({tag, ".Instr"},   32'(bus.Instr),   32'(m_instr));
        cmp({tag, ".InstrPC"}, 32'(bus.InstrPC), 32'(m_pc));
        cmp({tag, ".Valid"},   32'(bus.Valid),   32'(m_valid));
        cmp({tag, ".Halt"},    32'(bus.Halt),
            32'(m_drain_left > 0 || m_halted));
        cmp({tag, ".Done"},    32'(bus.Done),    32'(m_halted));
        cmp({tag, ".Count"},   32'(bus.InstrCount), 32'(exp_cnt));
    endtask

    task automatic step(input logic st, input logic br, input logic sl,
                        input logic [7:0] pc, input logic [8:0] ins,
                        input string tag);
        s_start = st; s_br = br; s_stall = sl; s_pc = pc; s_ins = ins;
        bus.Start   = st;
        bus.Branch  = br;
        bus.Stall   = sl;
        bus.PC      = pc;
        bus.InstrIn = ins;
        @(posedge clk);
        model_edge();
        #1;
        check_all(tag);
    endtask

    task automatic pulse_init(input string tag);
        Init = 1'b1;
        #2;
        model_reset();
        check_all(tag);
        Init = 1'b0;
    endtask

    initial begin
        n_err = 0;
        n_chk = 0;
        bus.Start = 1'b0; bus.Branch = 1'b0; bus.Stall = 1'b0;
        bus.PC = 8'h00; bus.InstrIn = 9'h000;
        Init = 1'b1;
        model_reset();
        #2;
        check_all("reset");
        Init = 1'b0;

        for (int i = 0; i < 3; i++) step(0, 0, 0, 8'h10, 9'h0AA, "idle");
        step(1, 0, 0, 8'h00, 9'h011, "start");
        cmp("start_nocap", 32'(bus.Valid), 32'd0);
        step(0, 0, 0, 8'h00, 9'h011, "cap0");
        cmp("cap0_instr", 32'(bus.Instr), 32'h011);
        step(0, 0, 0, 8'h01, 9'h022, "cap1");
        step(0, 0, 0, 8'h02, 9'h033, "cap2");
        cmp("cap2_pc", 32'(bus.InstrPC), 32'h02);
        step(0, 1, 0, 8'h05, 9'h044, "branch");
        cmp("branch_valid", 32'(bus.Valid), 32'd0);
        step(0, 0, 0, 8'h06, 9'h055, "cap6");
        step(0, 0, 1, 8'h07, 9'h066, "stall1");
        step(0, 0, 1, 8'h08, 9'h077, "stall2");
        cmp("stall_hold", 32'(bus.Instr), 32'h055);
        step(0, 1, 1, 8'h09, 9'h088, "br_stall");
        step(0, 0, 0, 8'h07, HALTW, "halt_cap");
        cmp("halt_rise", 32'(bus.Halt), 32'd1);
        for (int i = 0; i < DC; i++) step(0, 1, 0, 8'h20, 9'h099, "drain");
        cmp("done_rise", 32'(bus.Done), 32'd1);
        step(0, 0, 0, 8'h21, 9'h0AB, "halted");
        step(1, 0, 0, 8'h30, 9'h0CD, "restart");
        cmp("restart_halt", 32'(bus.Halt), 32'd0);
        step(0, 1, 0, 8'h31, HALTW, "wp_halt");
        cmp("wp_halt_low", 32'(bus.Halt), 32'd0);

        for (int i = 0; i < 300; i++) begin
            logic       st, br, sl;
            logic [8:0] ins;
            st  = ($urandom_range(0, 7) == 0);
            br  = ($urandom_range(0, 3) == 0);
            sl  = ($urandom_range(0, 3) == 0);
            ins = ($urandom_range(0, 11) == 0) ? HALTW
                                               : 9'($urandom_range(0, 510));
            step(st, br, sl, 8'($urandom), ins, "rand");
            if (i == 150) pulse_init("rand_init");
            if (i == 151) step(1, 0, 0, 8'h00, 9'h000, "rand_start");
        end

        if (!(m_drain_left > 0)) begin
            if (!m_started || m_halted) step(1, 0, 0, 8'h40, 9'h012, "pre");
            step(0, 0, 0, 8'h41, HALTW, "pre_halt");
        end
        step(0, 0, 0, 8'h42, 9'h013, "mid_drain");
        pulse_init("init_drain");
        step(0, 0, 0, 8'h43, 9'h014, "post_init");

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule

// File: doc/fetch_decode_reg.md
# fetch_decode_reg

- Pipeline register between the instruction fetch stage (PC / instruction ROM) and decode.
- Each cycle it captures the ROM word addressed by the current PC, together with that PC, and presents both to decode with a valid flag.
- It squashes wrong-path instructions after a taken branch and detects the HALT instruction.
- On HALT it drives `Halt` back to the fetch stage, drains the pipe, and raises `Done`; a run sequence is gated by `Start`.

## Interface

Parameters:
- `IW`, 9: instruction width.
- `AW`, 8: PC width.
- `HALT_ENC`, 9'h1FF: HALT instruction encoding.
- `NOP_ENC`, 9'h000: bubble encoding.
- `DRAIN_CYCLES`, 3: edges spent in DRAIN before HALTED (range 1..15).

Ports:
- `clk` in, 1: clock; all state updates on the rising edge.
- `Init` in, 1: reset, asynchronous, active-high.
- `Start` in, 1: single-cycle pulse that begins a run.
- `PC` in, AW: current PC from the fetch stage.
- `InstrIn` in, IW: instruction ROM word at `PC`.
- `Stall` in, 1: hold all pipeline registers.
- `Branch` in, 1: taken branch resolved this cycle; the current fetch is wrong-path.
- `Instr` out, IW: latched instruction to decode.
- `InstrPC` out, AW: PC of `Instr`.
- `Valid` out, 1: `Instr` is real (not a bubble).
- `Halt` out, 1: freeze the fetch stage.
- `Done` out, 1: program finished.
- `InstrCount` out, 16: retired-fetch counter (see Configuration).

## Operation

- FSM states: IDLE, RUN, DRAIN, HALTED.
- IDLE:
  - Registers load `NOP_ENC` with `Valid`=0.
  - `Start` moves the FSM to RUN.
- RUN, at each edge, in priority order:
  - `Branch`=1: load `NOP_ENC`/`Valid`=0; `InstrPC` takes `PC`. `Branch` takes priority over `Stall`.
  - `Stall`=1: hold `Instr`/`InstrPC`/`Valid`.
  - Otherwise, with `InstrIn`==`HALT_ENC`: load it with `Valid`=1, go to DRAIN, clear the drain counter.
  - Otherwise: load `InstrIn`/`PC` with `Valid`=1.
- `Branch` together with a HALT word on `InstrIn` means the HALT is wrong-path. Flush it and stay in RUN.
- DRAIN:
  - After the HALT capture, every edge loads `NOP_ENC`/`Valid`=0; `Branch` and `Stall` are ignored.
  - A 4-bit counter increments each edge. When it reaches `DRAIN_CYCLES`, go to HALTED.
- HALTED:
  - Outputs hold the bubble.
  - `Start` returns the FSM to RUN and clears `Done` and `Halt` on the same edge.
- `Start` in RUN or DRAIN is ignored.
- `Halt`=1 exactly in DRAIN and HALTED. `Done`=1 exactly in HALTED.

## Timing

- Reset values: `Instr`=`NOP_ENC`, `InstrPC`=0, `Valid`=0, `Halt`=0, `Done`=0, `InstrCount`=0, state IDLE.
- `Init` asserted mid-run restores all reset values immediately, without waiting for a clock edge.
- Capture latency:
  - `PC`/`InstrIn` sampled at edge k appear on the outputs after edge k.
  - All outputs are registered; there are no combinational paths from inputs to outputs.
- `Halt` rises after the edge that captures HALT, in the same cycle that `Instr`=`HALT_ENC` is shown. The fetch stage sees it at the next edge.
- `Done` rises exactly `DRAIN_CYCLES` edges after `Halt` rises.
- A `Start` pulse in IDLE: the first capture happens on the edge after the one that sampled `Start`.

## Configuration

- `FETCH_PERF_CNT_EN` defined:
  - `InstrCount` increments on every edge that loads `Valid`=1, saturating at 16'hFFFF.
  - Cleared by `Init` and by the edge that accepts `Start`.
- Not defined: `InstrCount` is tied to 16'h0000 and no counter flops are built.

## Test plan

- Reset, then three idle edges with no `Start` -> `Valid`=0, `Instr`=9'h000, `Halt`=0, `Done`=0.
- `Start`, then `PC`=0,1,2 with `InstrIn`=9'h011,9'h022,9'h033 -> one edge later `Instr`/`InstrPC` = 011/0, 022/1, 033/2 with `Valid`=1. With `FETCH_PERF_CNT_EN`, `InstrCount`=3.
- `Branch`=1 at `PC`=5 -> next cycle `Valid`=0, `Instr`=9'h000. `Stall`=1 for two edges -> outputs unchanged. `Branch`+`Stall` together -> flush.
- `InstrIn`=9'h1FF at `PC`=7 -> `Instr`=1FF, `Valid`=1, `Halt`=1. `Done`=1 exactly three edges later. `Branch` during DRAIN has no effect.
- `Branch`=1 with `InstrIn`=9'h1FF -> flushed, `Halt` stays 0. Then `Start` in HALTED -> RUN resumes and `InstrCount` resets. Finally, `Init` pulse mid-DRAIN -> all outputs at reset values before the next edge.
